// File: rtl/buffer_m1_sequencer.sv
// Mode-1 streaming sequencer: per-bank read/write enables and addresses,
// one pass per start, writes trailing reads by PE_LAT cycles.
module buffer_m1_sequencer #(
    parameter int N_BUF    = 8,
    parameter int ADDR_RAM = 10,
    parameter int PE_LAT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [ADDR_RAM-1:0]       cfg_rd_base,
    input  logic [ADDR_RAM-1:0]       cfg_wr_base,
    input  logic [ADDR_RAM:0]         cfg_len,
    input  logic [N_BUF-1:0]          cfg_bank_mask,
    input  logic                      cfg_skew_en,
    output logic [N_BUF-1:0]          m1_r_en,
    output logic [N_BUF*ADDR_RAM-1:0] m1_r_addr,
    output logic [N_BUF-1:0]          m1_w_en,
    output logic [N_BUF*ADDR_RAM-1:0] m1_w_addr,
    output logic                      busy,
    output logic                      done
);

    localparam int TW = ADDR_RAM + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       t;
    logic [TW-1:0]       t_last;
    logic [ADDR_RAM-1:0] lat_rd_base;
    logic [ADDR_RAM-1:0] lat_wr_base;
    logic [ADDR_RAM:0]   lat_len;
    logic [N_BUF-1:0]    lat_mask;
    logic                lat_skew;
    logic                run;
    logic                fire;

    // Last step index of the pass; only meaningful in RUN where len >= 1
    assign t_last = TW'(lat_len)
                  + (lat_skew ? TW'(N_BUF - 1) : '0)
                  + TW'(PE_LAT) - TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            t           <= '0;
            lat_rd_base <= '0;
            lat_wr_base <= '0;
            lat_len     <= '0;
            lat_mask    <= '0;
            lat_skew    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                t           <= '0;
                lat_rd_base <= cfg_rd_base;
                lat_wr_base <= cfg_wr_base;
                lat_len     <= cfg_len;
                lat_mask    <= cfg_bank_mask;
                lat_skew    <= cfg_skew_en;
            end else if (run && !stall) begin
                t <= t + TW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (cfg_len == '0) ? FIN : RUN;
            end
            RUN: begin
                if (!stall && t == t_last)
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run  = (state == RUN);
        busy = run;
        done = (state == FIN);
        fire = run & ~stall;
    end

    for (genvar i = 0; i < N_BUF; i++) begin : g_bank
        logic [TW-1:0] r_off;
        logic [TW-1:0] w_off;
        logic [TW-1:0] r_rel;
        logic [TW-1:0] w_rel;
        logic          r_ok;
        logic          w_ok;

        assign r_off = lat_skew ? TW'(i) : '0;
        assign w_off = r_off + TW'(PE_LAT);
        assign r_ok  = (t >= r_off);
        assign w_ok  = (t >= w_off);
        assign r_rel = t - r_off;
        assign w_rel = t - w_off;

        assign m1_r_en[i] = fire & lat_mask[i] & r_ok
                          & (r_rel < TW'(lat_len));
        assign m1_w_en[i] = fire & lat_mask[i] & w_ok
                          & (w_rel < TW'(lat_len));

        // Before a bank's window opens its address parks on the base
        assign m1_r_addr[i*ADDR_RAM +: ADDR_RAM] =
            lat_rd_base + (r_ok ? r_rel[ADDR_RAM-1:0] : '0);
        assign m1_w_addr[i*ADDR_RAM +: ADDR_RAM] =
            lat_wr_base + (w_ok ? w_rel[ADDR_RAM-1:0] : '0);
    end

endmodule

// File: tb/tb_buffer_m1_sequencer.sv
// Bench for buffer_m1_sequencer: table-driven passes, random passes
// against a per-word schedule model, plus reset/abort sequences.
module tb_buffer_m1_sequencer;

    localparam int N = 4;
    localparam int A = 6;
    localparam int L = 2;
    localparam int M = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic [A-1:0]   rd_base = '0;
    logic [A-1:0]   wr_base = '0;
    logic [A:0]     len = '0;
    logic [N-1:0]   mask = '0;
    logic           skew = 1'b0;
    logic [N-1:0]   r_en;
    logic [N-1:0]   w_en;
    logic [N*A-1:0] r_addr;
    logic [N*A-1:0] w_addr;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_m1_sequencer #(
        .N_BUF   (N),
        .ADDR_RAM(A),
        .PE_LAT  (L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .cfg_rd_base  (rd_base),
        .cfg_wr_base  (wr_base),
        .cfg_len      (len),
        .cfg_bank_mask(mask),
        .cfg_skew_en  (skew),
        .m1_r_en      (r_en),
        .m1_r_addr    (r_addr),
        .m1_w_en      (w_en),
        .m1_w_addr    (w_addr),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int           rd;
        int           wr;
        int           ln;
        int           mk;
        bit           sk;
        logic [127:0] sp;
        int           start_at;
        int           done_at;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: bank i handles read word k at progress step s_i+k and the
    // matching write at step s_i+k+L; a stalled step makes no progress.
    task automatic run_pass(input vec_t v, input string tag);
        int          tot;
        int          p;
        int          s;
        int          got_done;
        bit          st;
        logic [1:0]  eflags;
        logic [N-1:0] er;
        logic [N-1:0] ew;
        tot = (v.ln == 0) ? 0 : v.ln + (v.sk ? N - 1 : 0) + L;
        @(negedge clk);
        rd_base = A'(v.rd);
        wr_base = A'(v.wr);
        len     = (A+1)'(v.ln);
        mask    = N'(v.mk);
        skew    = v.sk;
        start   = 1'b1;
        stall   = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rd_base = A'($urandom);
        wr_base = A'($urandom);
        len     = (A+1)'($urandom);
        mask    = N'($urandom);
        skew    = 1'($urandom);
        stall   = v.sp[1];
        p = 0;
        got_done = -1;
        for (int n = 1; n < 400; n++) begin
            @(negedge clk);
            st = (n < 128) ? v.sp[n] : 1'b0;
            er = '0;
            ew = '0;
            if (done && got_done < 0)
                got_done = n;
            if (p < tot) begin
                eflags = 2'b10;
                for (int i = 0; i < N; i++) begin
                    s = v.sk ? i : 0;
                    for (int k = 0; k < v.ln; k++) begin
                        if (p == s + k && v.mk[i] && !st)
                            er[i] = 1'b1;
                        if (p == s + L + k && v.mk[i] && !st)
                            ew[i] = 1'b1;
                    end
                    if (p >= s)
                        check($sformatf("%s_raddr_c%0d_b%0d", tag, n, i),
                              64'(r_addr[i*A +: A]),
                              64'((v.rd + p - s) % M));
                    if (p >= s + L)
                        check($sformatf("%s_waddr_c%0d_b%0d", tag, n, i),
                              64'(w_addr[i*A +: A]),
                              64'((v.wr + p - s - L) % M));
                end
            end else begin
                eflags = 2'b01;
            end
            check($sformatf("%s_ctl_c%0d", tag, n),
                  64'({busy, done, r_en, w_en}),
                  64'({eflags, er, ew}));
            if (p >= tot)
                break;
            if (!st)
                p++;
            @(posedge clk);
            #1;
            start = (n + 1 == v.start_at);
            stall = (n + 1 < 128) ? v.sp[n+1] : 1'b0;
        end
        if (v.done_at >= 0)
            check({tag, "_done_cycle"}, 64'(got_done), 64'(v.done_at));
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, 64'({busy, done, r_en, w_en}), 64'(0));
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = '{5,  20, 3,  15, 1'b0, 128'h0,  0, 6};
        tbl[1] = '{0,  10, 2,  15, 1'b1, 128'h0,  0, 8};
        tbl[2] = '{62, 63, 4,  15, 1'b0, 128'h0,  0, 7};
        tbl[3] = '{8,  30, 4,  5,  1'b0, 128'hC,  0, 9};
        tbl[4] = '{7,  9,  0,  15, 1'b1, 128'h0,  0, 1};
        tbl[5] = '{1,  40, 5,  10, 1'b1, 128'h0,  2, 11};
        tbl[6] = '{3,  0,  64, 15, 1'b1, 128'h0,  0, 70};

        #1 rst = 1'b1;
        #1;
        check("reset_outs", 64'({r_en, w_en, busy, done, r_addr, w_addr}),
              64'(0));
        @(negedge clk);
        check("reset_held", 64'({busy, done}), 64'(0));
        rst = 1'b0;

        for (int j = 0; j < 7; j++)
            run_pass(tbl[j], $sformatf("vec%0d", j));

        // Abort: reset in cycle 3 of a long pass, then a clean pass
        @(negedge clk);
        rd_base = 6'd9;
        wr_base = 6'd33;
        len     = 7'd8;
        mask    = 4'hF;
        skew    = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_outs_zero",
              64'({r_en, w_en, busy, done, r_addr, w_addr}), 64'(0));
        @(negedge clk);
        check("abort_held", 64'({busy, done, r_en, w_en}), 64'(0));
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_%0d", n),
                  64'({busy, done, r_en, w_en}), 64'(0));
        end
        run_pass(tbl[0], "after_abort");

        for (int j = 0; j < 20; j++) begin
            rv.rd = int'($urandom_range(0, M - 1));
            rv.wr = int'($urandom_range(0, M - 1));
            rv.ln = int'($urandom_range(0, M));
            rv.mk = int'($urandom_range(0, 15));
            rv.sk = 1'($urandom);
            rv.sp = {$urandom, $urandom, $urandom, $urandom}
                  & {$urandom, $urandom, $urandom, $urandom};
            rv.start_at = ($urandom_range(0, 1) == 1)
                        ? int'($urandom_range(2, 10)) : 0;
            rv.done_at = -1;
            run_pass(rv, $sformatf("rnd%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_m1_sequencer.md
Name: buffer_m1_sequencer

Overview:
- Drives the mode-1 (PE-streaming) control bundle of the memory bank: per-bank read/write enables and per-bank addresses.
- Runs one streaming pass per start pulse: bank i reads `len` consecutive words from a read base. Bank i then writes `len` results to a write base, PE_LAT cycles later.
- Optional per-bank diagonal skew for systolic feeding.
- Sits directly upstream of the buffer bank's m1 ports; the top-level controller issues configuration and start.

Parameters:
- N_BUF, 8, number of buffer banks.
- ADDR_RAM, 10, bank address width.
- PE_LAT, 4, cycles from a bank's read enable to its matching write enable (PE pipeline depth incl. RAM read latency); legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pass request; honoured only in IDLE.
- stall  in  1  freeze request from downstream/PE array.
- cfg_rd_base  in  ADDR_RAM  first read address.
- cfg_wr_base  in  ADDR_RAM  first write address.
- cfg_len  in  ADDR_RAM+1  words per bank, 0..2^ADDR_RAM.
- cfg_bank_mask  in  N_BUF  banks taking part in the pass.
- cfg_skew_en  in  1  1: bank i offset by i cycles; 0: no offset.
- m1_r_en  out  N_BUF  per-bank read enable.
- m1_r_addr  out  N_BUF*ADDR_RAM  per-bank read address; bank i at bits [i*ADDR_RAM +: ADDR_RAM].
- m1_w_en  out  N_BUF  per-bank write enable.
- m1_w_addr  out  N_BUF*ADDR_RAM  per-bank write address, same packing.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pass-complete pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, counter t=0, latched config cleared; the reset takes effect immediately, including mid-pass. The pass is abandoned, with no done pulse.
- State registers: state, t (ADDR_RAM+2 bits), latched config. Outputs are decoded from these registers; stall gates the enables combinationally.
- Per-bank offset: s_i = cfg_skew_en ? i : 0.
- IDLE:
  - start=1 at an edge latches all cfg_*, sets t=0, and enters RUN. If latched len=0, it enters DONE directly instead.
  - start with len=0 gives busy=0 and no enables; done pulses on the next cycle.
- RUN:
  - busy=1.
  - T_total = len + (skew_en ? N_BUF-1 : 0) + PE_LAT.
  - Each edge with stall=0: t<=t+1. At t=T_total-1 with stall=0, next state is DONE.
  - With stall=1: t holds, all m1_r_en and m1_w_en are 0 that cycle, addresses hold their decoded values.
- Read decode:
  - r_i = t - s_i.
  - m1_r_en[i] = mask[i] & (0 <= r_i < len) & ~stall.
  - m1_r_addr_i = rd_base + r_i, modulo 2^ADDR_RAM (wraps); when not enabled it equals rd_base + r_i clipped to 0 when r_i < 0.
- Write decode:
  - w_i = t - s_i - PE_LAT.
  - m1_w_en[i] = mask[i] & (0 <= w_i < len) & ~stall.
  - m1_w_addr_i = wr_base + w_i, modulo 2^ADDR_RAM, same clipping rule.
- Masked-off banks: enables stay 0 for the whole pass; their addresses follow the decode.
- DONE: lasts one cycle with done=1, busy=0, all enables 0; next state is IDLE.
- Latency: the first read enable appears in the cycle after the start edge; done appears in cycle T_total+1 after the start edge, plus the number of stalled RUN cycles.
- Mid-pass events:
  - start while in RUN or DONE is ignored.
  - cfg_* changes during a pass have no effect.
  - stall in IDLE or DONE has no effect.
- Read and write enables for the same bank may be high in the same cycle. The block does not check rd/wr address overlap; the controller must keep the regions disjoint.

Test Plan:
Settings for all scenarios: N_BUF=4, ADDR_RAM=6, PE_LAT=2; cycle n = n-th cycle after the start edge.
1. Reset check: assert rst asynchronously mid-cycle → all outputs 0 immediately; busy=0, done=0 while rst held.
2. No-skew pass: len=3, mask=1111, skew off, rd_base=5, wr_base=20 → cycles 1-3: m1_r_en=1111 with all r_addr 5,6,7. Cycles 3-5: m1_w_en=1111 with w_addr 20,21,22. done=1 in cycle 6 only; busy=1 in cycles 1-5.
3. Skewed pass: len=2, mask=1111, skew on, rd_base=0 → bank0 reads cycles 1-2, bank3 reads cycles 4-5 (addr 0,1). Bank3 writes cycles 6-7; done in cycle 8.
4. Address wrap: rd_base=62, wr_base=63, len=4, skew off → read addrs 62,63,0,1; write addrs 63,0,1,2.
5. Stall with partial mask: mask=0101, len=4, stall=1 during cycles 2-3 → enables 0 in cycles 2-3; bank0 read addrs continue from base+1 in cycle 4. Banks 1 and 3 never enabled; done delayed by 2 to cycle 9.
6. Illegal requests and abort:
   - start with len=0 → no enables, done in cycle 1.
   - start pulsed in cycle 2 of a running pass → ignored, pass unchanged.
   - rst in cycle 3 of a pass → outputs 0, no done; a new start afterwards runs normally.
